// File: rtl/hash_dispatch_pkg.sv
// Shared types and sizing for the hash dispatch stage.
package hash_dispatch_pkg;

  localparam int unsigned KEY_W           = 32;
  localparam int unsigned ENG_ID_W        = 2;
  localparam int unsigned ENGINE_N        = 1 << ENG_ID_W;
  localparam int unsigned MAX_OUTSTANDING = 2;

  typedef logic [ENG_ID_W-1:0] engine_id_t;

  typedef struct packed {
    logic [KEY_W-1:0] k;
    engine_id_t       h;
  } dispatch_req_t;

  localparam int unsigned REQ_W = $bits(dispatch_req_t);

  // Counter must hold 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/hash_dispatch_if.sv
// Request, engine-offer, completion and status signals of the dispatch stage.
interface hash_dispatch_if;
  import hash_dispatch_pkg::*;

  logic                    in_vld;
  logic [KEY_W-1:0]        in_k;
  engine_id_t              in_h;
  logic                    in_rdy;
  logic [ENGINE_N-1:0]     out_vld;
  logic [KEY_W-1:0]        out_k;
  logic [ENGINE_N-1:0]     out_rdy;
  logic [ENGINE_N-1:0]     cpl;
  logic                    busy;

  modport slave (
    input  in_vld, in_k, in_h, out_rdy, cpl,
    output in_rdy, out_vld, out_k, busy
  );

  modport master (
    output in_vld, in_k, in_h, out_rdy, cpl,
    input  in_rdy, out_vld, out_k, busy
  );

endinterface

// File: rtl/hash_dispatch_skid.sv
// Generic 2-entry valid/ready FIFO; entry 0 is always the head and keeps
// its last value once drained.
module hash_dispatch_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_data_i,
  output logic         push_rdy_o,
  output logic         pop_vld_o,
  output logic [W-1:0] pop_data_o,
  input  logic         pop_rdy_i
);

  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic         push, pop;

  assign push_rdy_o = (occ_q != 2'd2);
  assign pop_vld_o  = (occ_q != 2'd0);
  assign pop_data_o = e0_q;
  assign push       = push_vld_i & push_rdy_o;
  assign pop        = pop_rdy_i & pop_vld_o;

  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_data_i;
        else               e1_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) e0_d = e1_q;
        occ_d = occ_q - 2'd1;
      end
      // Only reachable at occupancy 1: the new entry becomes the head.
      2'b11:   e0_d = push_data_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

endmodule

// File: rtl/hash_dispatch.sv
// Routes hashed keys in order to per-bucket engines under a per-engine
// outstanding-request credit limit.
module hash_dispatch
  import hash_dispatch_pkg::*;
#(
  parameter int unsigned MAX_OUT = MAX_OUTSTANDING
) (
  input logic           clk,
  input logic           arst,
  hash_dispatch_if.slave dp
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUT);

  dispatch_req_t       push_req, head;
  logic [REQ_W-1:0]    head_bits;
  logic                head_vld;
  logic                issue;
  logic [ENGINE_N-1:0] credit_ok, cnt_nz, sel;

  assign push_req = '{k: dp.in_k, h: dp.in_h};

  hash_dispatch_skid #(.W(REQ_W)) u_skid (
    .clk         (clk),
    .rst         (arst),
    .push_vld_i  (dp.in_vld),
    .push_data_i (push_req),
    .push_rdy_o  (dp.in_rdy),
    .pop_vld_o   (head_vld),
    .pop_data_o  (head_bits),
    .pop_rdy_i   (issue)
  );

  assign head       = dispatch_req_t'(head_bits);
  assign sel        = ENGINE_N'(1) << head.h;
  assign dp.out_vld = (head_vld && credit_ok[head.h]) ? sel : '0;
  assign dp.out_k   = head.k;
  assign issue      = |(dp.out_vld & dp.out_rdy);
  assign dp.busy    = head_vld | (|cnt_nz);

  // Per-engine outstanding counters; issue and completion together cancel.
  for (genvar g = 0; g < ENGINE_N; g++) begin : g_eng
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, dec;

    assign inc          = issue && (head.h == engine_id_t'(g));
    assign dec          = dp.cpl[g];
    assign credit_ok[g] = (cnt_q < CNT_W'(MAX_OUT));
    assign cnt_nz[g]    = (cnt_q != '0);

    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)                     cnt_d = cnt_q + CNT_W'(1);
      else if (dec && !inc && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge arst) begin
      if (arst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    a_cnt_max: assert property (@(posedge clk) disable iff (arst)
      cnt_q <= CNT_W'(MAX_OUT));
    a_cpl_underflow: assert property (@(posedge clk) disable iff (arst)
      !(dec && !inc && cnt_q == '0));
  end

endmodule

// File: tb/tb_hash_dispatch.sv
// Randomized bench for hash_dispatch against a queue-based reference model.
module tb_hash_dispatch;
  import hash_dispatch_pkg::*;

  typedef struct {
    logic [31:0] k;
    int          h;
  } mreq_t;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mreq_t       q[$];
  int          cnt_m[4];
  logic [31:0] last_k;

  hash_dispatch_if bus();

  hash_dispatch dut (
    .clk  (clk),
    .arst (arst),
    .dp   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_vld();
    if (q.size() == 0) return 4'b0000;
    if (cnt_m[q[0].h] >= 2) return 4'b0000;
    return 4'b0001 << q[0].h;
  endfunction

  function automatic logic m_busy();
    int s = 0;
    for (int e = 0; e < 4; e++) s += cnt_m[e];
    return (q.size() != 0) || (s != 0);
  endfunction

  task automatic check_outputs();
    check("in_rdy",  64'(bus.in_rdy),  64'(q.size() < 2));
    check("out_vld", 64'(bus.out_vld), 64'(m_vld()));
    check("out_k",   64'(bus.out_k),   64'(q.size() != 0 ? q[0].k : last_k));
    check("busy",    64'(bus.busy),    64'(m_busy()));
  endtask

  function automatic void m_clear();
    q.delete();
    for (int e = 0; e < 4; e++) cnt_m[e] = 0;
    last_k = '0;
  endfunction

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [31:0] k, input logic [1:0] h,
                      input logic [3:0] ordy, input logic [3:0] c);
    logic [3:0] ev;
    logic       er;
    int         ie;
    logic       iss;
    ev = m_vld();
    er = (q.size() < 2);
    bus.in_vld  = v;
    bus.in_k    = k;
    bus.in_h    = h;
    bus.out_rdy = ordy;
    bus.cpl     = c;
    @(posedge clk);
    iss = |(ev & ordy);
    ie  = (q.size() != 0) ? q[0].h : -1;
    if (iss) begin
      last_k = q[0].k;
      void'(q.pop_front());
    end
    for (int e = 0; e < 4; e++) begin
      if (iss && e == ie && !c[e]) cnt_m[e]++;
      else if (c[e] && !(iss && e == ie) && cnt_m[e] > 0) cnt_m[e]--;
    end
    if (v && er) q.push_back('{k: k, h: int'(h)});
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    bus.in_vld  = 1'b0;
    bus.out_rdy = '0;
    bus.cpl     = '0;
    arst = 1'b1;
    #1;
    check("rst_out_vld", 64'(bus.out_vld), 64'(0));
    check("rst_busy",    64'(bus.busy),    64'(0));
    check("rst_in_rdy",  64'(bus.in_rdy),  64'(1));
    m_clear();
    @(negedge clk);
    arst = 1'b0;
    check("rst_out_k", 64'(bus.out_k), 64'(0));
  endtask

  // Random cycle; completions only for engines the model knows are outstanding.
  task automatic rand_step(input bit h0_only, input int ordy_pct, input int cpl_pct);
    logic [3:0] ordy, c;
    for (int e = 0; e < 4; e++) begin
      ordy[e] = ($urandom_range(0, 99) < ordy_pct);
      c[e]    = (cnt_m[e] > 0) && ($urandom_range(0, 99) < cpl_pct);
    end
    step(($urandom_range(0, 3) != 0), $urandom(),
         h0_only ? 2'd0 : 2'($urandom_range(0, 3)), ordy, c);
  endtask

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_k    = '0;
    bus.in_h    = '0;
    bus.out_rdy = '0;
    bus.cpl     = '0;
    m_clear();
    @(negedge clk);
    do_reset();

    // Single request to engine 2, then its completion.
    step(1'b1, 32'hDEADBEEF, 2'd2, 4'hF, 4'h0);
    check("single_offer", 64'(bus.out_vld), 64'(4'b0100));
    check("single_key",   64'(bus.out_k),   64'(32'hDEADBEEF));
    step(1'b0, 32'h0, 2'd0, 4'hF, 4'h0);
    check("single_busy",  64'(bus.busy),    64'(1));
    step(1'b0, 32'h0, 2'd0, 4'hF, 4'b0100);
    check("single_idle",  64'(bus.busy),    64'(0));

    // Credit limit on engine 0 with a full FIFO behind it.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 2'd0, 4'hF, 4'h0);
    check("credit_full",  64'(bus.in_rdy),  64'(0));
    step(1'b0, 32'h0, 2'd0, 4'hF, 4'b0001);
    step(1'b0, 32'h0, 2'd0, 4'hF, 4'h0);

    // Mid-run reset, then a request to engine 0 must issue without completions.
    do_reset();
    step(1'b1, 32'hCAFE0000, 2'd0, 4'hF, 4'h0);
    check("post_rst_offer", 64'(bus.out_vld), 64'(4'b0001));

    for (int i = 0; i < 300; i++) rand_step(1'b1, 90, 10);
    for (int i = 0; i < 400; i++) rand_step(1'b0, 40, 30);
    do_reset();
    for (int i = 0; i < 400; i++) rand_step(1'b0, 85, 50);
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      rand_step(($urandom_range(0, 1) == 0), 60, 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_dispatch.md
Name: hash_dispatch

Overview:
- Sits directly downstream of the hash stage.
- Accepts a key together with its hash bucket index (the hash module's output `h`) on a valid/ready handshake.
- Routes each key to the engine whose index equals the bucket. There are E = 2**H engines.
- Enforces a per-engine outstanding-request limit using completion pulses returned by the engines. Dispatch is strictly in order, with head-of-line blocking.

Parameters:
- K, 32, key width in bits.
- H, 2, bucket index width; engine count E = 2**H.
- MAX_OUTSTANDING, 2, maximum issued-but-uncompleted requests per engine (range 1..15).

Ports:
- clk  input  1  clock; all state on rising edge.
- arst  input  1  asynchronous active-high reset.
- in_vld  input  1  request valid.
- in_k  input  K  request key.
- in_h  input  H  bucket index from the hash stage.
- in_rdy  output  1  request accepted when in_vld & in_rdy.
- out_vld  output  E  one-hot; bit e means a request is offered to engine e.
- out_k  output  K  key of the offered request (shared by all engines).
- out_rdy  input  E  per-engine ready.
- cpl  input  E  per-engine completion pulse, one cycle per finished request.
- busy  output  1  any request buffered or outstanding.

Behaviour:
- Reset, asynchronous on arst=1:
  - Buffer empty; all counters 0.
  - out_vld=0, out_k=0, busy=0, in_rdy=1.
  - Assertion mid-operation discards buffered requests and zeroes counters. No output glitches beyond the reset values.
- Input buffer:
  - 2-entry FIFO holding {k,h}.
  - in_rdy = !full, derived from registered occupancy only. No combinational path from out_rdy to in_rdy.
  - Simultaneous push and pop when full is not permitted; when occupancy is 1 it is allowed and occupancy stays 1.
- Latency: a request accepted at edge t is first offered (out_vld) in cycle t+1 at the earliest. There is no bypass.
- Offer rule:
  - With head = FIFO head and e = head.h: out_vld[e] = fifo_nonempty & (cnt[e] < MAX_OUTSTANDING). All other bits are 0.
  - out_k = head.k whenever the FIFO is non-empty; it holds its last value when empty.
- Issue: issue = |(out_vld & out_rdy). On issue, pop the head and cnt[e] += 1.
- Stability: once out_vld[e] is asserted it stays asserted with stable out_k until out_rdy[e]. Counters only grow on issue, so credit for e cannot be withdrawn while an offer is pending.
- Completion: each cpl[e] pulse decrements cnt[e].
  - Issue and completion on the same engine in the same cycle: cnt[e] unchanged.
  - cpl[e] with cnt[e]==0 is a protocol error. A simulation assertion fires and the counter saturates at 0.
- Counters:
  - Width = $clog2(MAX_OUTSTANDING+1).
  - Never exceed MAX_OUTSTANDING; a simulation assertion checks this.
- Head-of-line: a head targeting an engine with no credit blocks all later requests, even those for idle engines. Strict ordering is required by downstream consumers.
- busy = fifo_nonempty | (|cnt), registered-state-derived.

Decomposition:
- h_pkg gains:
  - `engine_id_t` (H bits).
  - `dispatch_req_t` struct {k, h}.
  - `ENGINE_N` = 2**H.
  - The outstanding-counter width function.
- Sub-module `hash_dispatch_skid`: a generic 2-entry valid/ready FIFO parameterised on payload width, reusable by other stages.
- Per-engine counters stay in the top level as a generate loop.

Test Plan (K=32, H=2, MAX_OUTSTANDING=2):
- Reset then single request k=0xDEADBEEF, h=2, out_rdy=4'b1111 -> out_vld=4'b0100 one cycle after acceptance, out_k=0xDEADBEEF; pop next edge; busy=1 until cpl[2] pulses, then busy=0.
- Credit limit with all h=0 (pathological hash), out_rdy=1111, no cpl:
  - Requests 1 and 2 issue to engine 0.
  - Request 3 is held with out_vld=0.
  - FIFO fills and in_rdy=0 after request 4.
  - One cpl[0] releases request 3 on the next cycle.
- Head-of-line blocking: engine 1 at cnt=2; head h=1 then h=3 -> out_vld stays 0 for both until cpl[1]; then the h=1 request issues, followed by h=3.
- Backpressure stability: out_rdy[3]=0 for 5 cycles with head h=3 -> out_vld=4'b1000 and out_k constant all 5 cycles; issue on the cycle out_rdy[3] rises.
- Simultaneous issue and cpl on engine 2 at cnt=1 -> cnt stays 1, busy stays 1; back-to-back throughput of 1 request/cycle sustained with in_vld=1 while credits allow.
- arst pulse with 2 buffered requests and cnt[0]=2 -> out_vld=0, busy=0, in_rdy=1 immediately; first post-reset request to h=0 issues without needing cpl.
